// File: rtl/fwrisc_mds_pkg.sv
// Shared definitions for the MDS issue sequencer and the MDS unit:
// op codes, issuer state encoding and a destination helper.
package fwrisc_mds_pkg;

   localparam logic [3:0] MDS_OP_SLL = 4'b0000;
   localparam logic [3:0] MDS_OP_SRL = 4'b0001;
   localparam logic [3:0] MDS_OP_SRA = 4'b0010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      WB    = 2'd3
   } mds_state_e;

   // Writes to x0 are architecturally discarded.
   function automatic logic is_x0(input logic [4:0] rd);
      return (rd == 5'd0);
   endfunction

endpackage

// File: rtl/fwrisc_mds_issue_if.sv
// Decode request, MDS unit handshake and register-file write port of the
// MDS issue sequencer. master = issuer side, slave = surrounding core/unit.
interface fwrisc_mds_issue_if;

   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic [4:0]  req_rd;

   logic [3:0]  mds_op;
   logic [31:0] mds_in_a;
   logic [31:0] mds_in_b;
   logic        mds_in_valid;
   logic [31:0] mds_out;
   logic        mds_out_valid;

   logic [4:0]  rd_waddr;
   logic [31:0] rd_wdata;
   logic        rd_wen;

   logic        busy;
   logic        err;

   modport master (
      input  req_valid, req_op, req_rs1, req_rs2, req_rd,
      input  mds_out, mds_out_valid,
      output req_ready, mds_op, mds_in_a, mds_in_b, mds_in_valid,
      output rd_waddr, rd_wdata, rd_wen, busy, err
   );

   modport slave (
      output req_valid, req_op, req_rs1, req_rs2, req_rd,
      output mds_out, mds_out_valid,
      input  req_ready, mds_op, mds_in_a, mds_in_b, mds_in_valid,
      input  rd_waddr, rd_wdata, rd_wen, busy, err
   );

endinterface

// File: rtl/fwrisc_mds_watchdog.sv
// WAIT-state cycle counter for the MDS issuer. Instantiated only when
// FWRISC_MDS_TIMEOUT_EN is defined.
module fwrisc_mds_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clock,
   input  logic reset,
   input  logic i_clear,
   input  logic i_count,
   output logic o_expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count <= 8'd0;
      end else if (i_clear) begin
         r_count <= 8'd0;
      end else if (i_count) begin
         r_count <= r_count + 8'd1;
      end
   end

   // r_count holds the number of WAIT cycles already completed, so this
   // fires during the last permitted WAIT cycle.
   assign o_expired = i_count && (r_count == LIMIT);

endmodule

// File: rtl/fwrisc_mds_issue.sv
// Issue/writeback sequencer for the multi-cycle mul/div/shift unit.
// Optional WAIT timeout with err flag: define FWRISC_MDS_TIMEOUT_EN.
module fwrisc_mds_issue
   import fwrisc_mds_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic               clock,
   input  logic               reset,
   fwrisc_mds_issue_if.master bus
);

   mds_state_e  r_state;
   mds_state_e  w_state_nxt;

   logic [3:0]  r_mds_op;
   logic [31:0] r_mds_a;
   logic [31:0] r_mds_b;
   logic        r_mds_valid;
   logic [4:0]  r_waddr;
   logic [31:0] r_wdata;
   logic        r_wen;

   logic        w_accept;
   logic        w_timeout;
   logic        w_done;

   assign w_accept = (r_state == IDLE) && bus.req_valid;
   // A result arriving in the limit cycle takes priority over the timeout.
   assign w_done   = (r_state == WAIT) && (bus.mds_out_valid || w_timeout);

`ifdef FWRISC_MDS_TIMEOUT_EN
   logic r_err;

   fwrisc_mds_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock     (clock),
      .reset     (reset),
      .i_clear   (r_state == ISSUE),
      .i_count   (r_state == WAIT),
      .o_expired (w_timeout)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= 1'b0;
      end else if (w_done && !bus.mds_out_valid) begin
         r_err <= 1'b1;
      end
   end

   assign bus.err = r_err;
`else
   // Without the watchdog the limit parameter has no effect.
   assign w_timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
   assign bus.err   = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = ISSUE;
         ISSUE:   w_state_nxt = WAIT;
         WAIT:    if (w_done) w_state_nxt = WB;
         WB:      w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mds_op    <= 4'd0;
         r_mds_a     <= 32'd0;
         r_mds_b     <= 32'd0;
         r_mds_valid <= 1'b0;
         r_waddr     <= 5'd0;
         r_wdata     <= 32'd0;
         r_wen       <= 1'b0;
      end else begin
         r_mds_valid <= w_accept;
         r_wen       <= w_done && !is_x0(r_waddr);
         if (w_accept) begin
            r_mds_op <= bus.req_op;
            r_mds_a  <= bus.req_rs1;
            r_mds_b  <= bus.req_rs2;
            r_waddr  <= bus.req_rd;
         end
         if (w_done) begin
            r_wdata <= bus.mds_out_valid ? bus.mds_out : 32'd0;
         end
      end
   end

   assign bus.req_ready    = (r_state == IDLE);
   assign bus.busy         = (r_state != IDLE);
   assign bus.mds_op       = r_mds_op;
   assign bus.mds_in_a     = r_mds_a;
   assign bus.mds_in_b     = r_mds_b;
   assign bus.mds_in_valid = r_mds_valid;
   assign bus.rd_waddr     = r_waddr;
   assign bus.rd_wdata     = r_wdata;
   assign bus.rd_wen       = r_wen;

endmodule

// File: tb/tb_fwrisc_mds_issue.sv
// Randomized self-checking bench for fwrisc_mds_issue with a behavioural
// MDS unit and register-file scoreboard.
module tb_fwrisc_mds_issue;
   import fwrisc_mds_pkg::*;

   localparam int unsigned TMO = 64;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      int          lat;
   } txn_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   fwrisc_mds_issue_if bus ();

   fwrisc_mds_issue #(
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [31:0] exp_rf [32];
   logic [31:0] dut_rf [32];
   int          exp_wen_cnt = 0;
   int          dut_wen_cnt = 0;
   logic [31:0] last_wdata = 32'd0;
   txn_t        nx;

   always @(negedge clock) begin
      if (bus.rd_wen === 1'b1) begin
         dut_rf[bus.rd_waddr] = bus.rd_wdata;
         dut_wen_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout obs=hang exp=finish");
      $fatal(1, "bench hung");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      cyc++;
   endtask

   function automatic logic [31:0] ref_mds(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         MDS_OP_SLL: return a << sh;
         MDS_OP_SRL: return a >> sh;
         MDS_OP_SRA: return 32'($signed(a) >>> sh);
         default:    return a * b + {28'd0, op};
      endcase
   endfunction

   function automatic txn_t gen_txn();
      txn_t t;
      int   k;
      k = $urandom_range(0, 3);
      t.op  = (k == 3) ? 4'($urandom) : 4'(k);
      t.a   = $urandom;
      t.b   = $urandom;
      t.rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      t.lat = $urandom_range(1, 6);
      return t;
   endfunction

   task automatic junk_req();
      bus.req_valid = 1'($urandom);
      bus.req_op    = 4'($urandom);
      bus.req_rs1   = $urandom;
      bus.req_rs2   = $urandom;
      bus.req_rd    = 5'($urandom);
   endtask

   task automatic present(input txn_t t);
      bus.req_valid = 1'b1;
      bus.req_op    = t.op;
      bus.req_rs1   = t.a;
      bus.req_rs2   = t.b;
      bus.req_rd    = t.rd;
   endtask

   // Called at a negedge; returns at the negedge of the first IDLE cycle after WB.
   task automatic run_txn(input txn_t t, input bit hold_next, output int t_acc);
      int          waited;
      logic [31:0] res;
      res = ref_mds(t.op, t.a, t.b);
      waited = 0;
      while (bus.req_ready !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check_eq("ready_before_accept", bus.req_ready, 32'd1);
      present(t);
      t_acc = cyc;
      tick();
      check_eq("issue_valid", bus.mds_in_valid, 32'd1);
      check_eq("issue_op", bus.mds_op, 32'(t.op));
      check_eq("issue_a", bus.mds_in_a, t.a);
      check_eq("issue_b", bus.mds_in_b, t.b);
      check_eq("issue_busy", bus.busy, 32'd1);
      check_eq("issue_err", bus.err, 32'd0);
      junk_req();
      tick();
      for (int i = 0; i < t.lat; i++) begin
         check_eq("wait_valid", bus.mds_in_valid, 32'd0);
         check_eq("wait_wen", bus.rd_wen, 32'd0);
         check_eq("wait_busy", {bus.busy, bus.req_ready}, 32'd2);
         bus.mds_out_valid = (i == t.lat - 1);
         bus.mds_out       = (i == t.lat - 1) ? res : $urandom;
         junk_req();
         tick();
      end
      bus.mds_out_valid = 1'b0;
      check_eq("wb_wen", bus.rd_wen, 32'(t.rd != 5'd0));
      check_eq("wb_waddr", bus.rd_waddr, 32'(t.rd));
      check_eq("wb_wdata", bus.rd_wdata, res);
      check_eq("wb_busy", bus.busy, 32'd1);
      check_eq("wb_err", bus.err, 32'd0);
      check_eq("wb_hold_a", bus.mds_in_a, t.a);
      check_eq("wb_hold_b", bus.mds_in_b, t.b);
      check_eq("wb_hold_op", bus.mds_op, 32'(t.op));
      if (t.rd != 5'd0) begin
         exp_rf[t.rd] = res;
         exp_wen_cnt++;
      end
      last_wdata = res;
      if (hold_next) present(nx);
      else bus.req_valid = 1'b0;
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_in_valid"}, bus.mds_in_valid, 32'd0);
      check_eq({tag, "_op"}, bus.mds_op, 32'd0);
      check_eq({tag, "_a"}, bus.mds_in_a, 32'd0);
      check_eq({tag, "_b"}, bus.mds_in_b, 32'd0);
      check_eq({tag, "_wen"}, bus.rd_wen, 32'd0);
      check_eq({tag, "_waddr"}, bus.rd_waddr, 32'd0);
      check_eq({tag, "_wdata"}, bus.rd_wdata, 32'd0);
      check_eq({tag, "_err"}, bus.err, 32'd0);
      check_eq({tag, "_ready"}, bus.req_ready, 32'd1);
      check_eq({tag, "_busy"}, bus.busy, 32'd0);
   endtask

   initial begin
      txn_t t0, t1, cur, nxt;
      int   ta, tb2, ta_prev;
      bit   hold, prev_hold;
      int   prev_lat;

      for (int r = 0; r < 32; r++) begin
         exp_rf[r] = 32'd0;
         dut_rf[r] = 32'd0;
      end
      bus.req_valid = 1'b0;
      bus.req_op = 4'd0;
      bus.req_rs1 = 32'd0;
      bus.req_rs2 = 32'd0;
      bus.req_rd = 5'd0;
      bus.mds_out = 32'd0;
      bus.mds_out_valid = 1'b0;

      tick();
      tick();
      check_reset_outputs("reset");
      reset = 1'b0;
      tick();

      // Directed SLL
      t0 = '{op: MDS_OP_SLL, a: 32'd1, b: 32'd4, rd: 5'd5, lat: 4};
      run_txn(t0, 1'b0, ta);
      check_eq("sll_ready_after", bus.req_ready, 32'd1);

      // x0 destination
      t0 = '{op: MDS_OP_SRA, a: 32'h8000_0000, b: 32'd31, rd: 5'd0, lat: 3};
      run_txn(t0, 1'b0, ta);
      check_eq("x0_busy_after", bus.busy, 32'd0);

      // Back-to-back, 1-cycle unit
      t0 = '{op: MDS_OP_SRL, a: 32'hF000_0000, b: 32'd4, rd: 5'd3, lat: 1};
      t1 = '{op: MDS_OP_SLL, a: 32'h0000_00FF, b: 32'd8, rd: 5'd3, lat: 1};
      nx = t1;
      run_txn(t0, 1'b1, ta);
      run_txn(t1, 1'b0, tb2);
      check_eq("b2b_spacing", 32'(tb2 - ta), 32'd4);

      // Spurious response in IDLE
      bus.mds_out_valid = 1'b1;
      bus.mds_out = 32'hDEAD;
      tick();
      bus.mds_out_valid = 1'b0;
      check_eq("spur_wen", bus.rd_wen, 32'd0);
      check_eq("spur_ready", bus.req_ready, 32'd1);
      check_eq("spur_wdata", bus.rd_wdata, last_wdata);
      tick();
      check_eq("spur_wen2", bus.rd_wen, 32'd0);

      // Result in the same cycle as the timeout limit is written normally
      t0 = '{op: MDS_OP_SLL, a: 32'h1234_5678, b: 32'd1, rd: 5'd9, lat: TMO};
      run_txn(t0, 1'b0, ta);

      // Reset mid-WAIT
      t0 = '{op: MDS_OP_SRL, a: 32'hAAAA_5555, b: 32'd2, rd: 5'd12, lat: 10};
      present(t0);
      tick();
      check_eq("rst_issue_valid", bus.mds_in_valid, 32'd1);
      bus.req_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      check_reset_outputs("midwait");
      tick();
      reset = 1'b0;
      bus.mds_out_valid = 1'b1;
      bus.mds_out = 32'hBEEF;
      tick();
      bus.mds_out_valid = 1'b0;
      check_eq("rst_late_wen", bus.rd_wen, 32'd0);
      tick();
      check_eq("rst_late_wen2", bus.rd_wen, 32'd0);
      check_eq("rst_late_ready", bus.req_ready, 32'd1);

`ifdef FWRISC_MDS_TIMEOUT_EN
      // No response: timeout after TMO WAIT cycles
      t0 = '{op: MDS_OP_SRA, a: 32'h5, b: 32'd1, rd: 5'd7, lat: 0};
      present(t0);
      tick();
      bus.req_valid = 1'b0;
      tick();
      for (int i = 0; i < int'(TMO); i++) begin
         check_eq("tmo_wait_wen", bus.rd_wen, 32'd0);
         check_eq("tmo_wait_busy", bus.busy, 32'd1);
         tick();
      end
      check_eq("tmo_wen", bus.rd_wen, 32'd1);
      check_eq("tmo_wdata", bus.rd_wdata, 32'd0);
      check_eq("tmo_err", bus.err, 32'd1);
      exp_rf[7] = 32'd0;
      exp_wen_cnt++;
      tick();
      check_eq("tmo_err_sticky", bus.err, 32'd1);
      check_eq("tmo_ready", bus.req_ready, 32'd1);
      bus.mds_out_valid = 1'b1;
      bus.mds_out = 32'hCAFE;
      tick();
      bus.mds_out_valid = 1'b0;
      check_eq("tmo_late_wen", bus.rd_wen, 32'd0);
      check_eq("tmo_late_err", bus.err, 32'd1);
      last_wdata = 32'd0;
      t0 = '{op: MDS_OP_SLL, a: 32'h3, b: 32'd2, rd: 5'd7, lat: 2};
      run_txn(t0, 1'b0, ta);
`endif

      // Randomized sequence
      cur = gen_txn();
      prev_hold = 1'b0;
      prev_lat = 0;
      ta_prev = 0;
      for (int k = 0; k < 24; k++) begin
         nxt = gen_txn();
         hold = 1'($urandom);
         nx = nxt;
         run_txn(cur, hold, ta);
         if (prev_hold) check_eq("rand_spacing", 32'(ta - ta_prev), 32'(3 + prev_lat));
         if (!hold) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
         end
         prev_hold = hold;
         prev_lat = cur.lat;
         ta_prev = ta;
         cur = nxt;
      end
      bus.req_valid = 1'b0;
      tick();
      tick();

      for (int r = 1; r < 32; r++) check_eq($sformatf("rf_x%0d", r), dut_rf[r], exp_rf[r]);
      check_eq("wen_count", 32'(dut_wen_cnt), 32'(exp_wen_cnt));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
